// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: feeds one frame of samples through fir_filter, holding
// each sample HOLD_CYCLES clocks, capturing one output per sample, then flushing.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, frame_len           frame start pulse and sample count (latched)
//   s_valid, s_data, s_ready   input sample stream
//   fir_data_in, fir_out       registered drive to / output from fir_filter
//   m_valid, m_data, m_ready   captured filter output stream
//   busy, done                 activity flag and end-of-frame pulse
//   in_count, out_count        samples accepted / output beats delivered
module fir_stream_sequencer #(
    parameter int DATA_W      = 16,
    parameter int TAPS        = 17,
    parameter int HOLD_CYCLES = 2,
    parameter int LEN_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] fir_data_in,
    input  logic [DATA_W-1:0] fir_out,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  in_count,
    output logic [LEN_W:0]    out_count
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int FW = $clog2(TAPS);

    localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_ONE   = HW'(1);
    localparam logic [FW-1:0]    FLUSH_LAST = FW'(TAPS - 2);
    localparam logic [FW-1:0]    FLUSH_ONE  = FW'(1);
    localparam logic [LEN_W-1:0] IN_ONE     = LEN_W'(1);
    localparam logic [LEN_W:0]   OUT_ONE    = (LEN_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        HOLD,
        EMIT,
        FLUSH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
    // Set once the real samples are exhausted and zeros are being fed.
    logic               flush_ph_q, flush_ph_d;
    logic [DATA_W-1:0]  fir_q, fir_d;
    logic               m_valid_q, m_valid_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic [LEN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [LEN_W:0]     out_cnt_q, out_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            hold_q      <= '0;
            flush_cnt_q <= '0;
            flush_ph_q  <= 1'b0;
            fir_q       <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            flush_cnt_q <= flush_cnt_d;
            flush_ph_q  <= flush_ph_d;
            fir_q       <= fir_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hold_d      = hold_q;
        flush_cnt_d = flush_cnt_q;
        flush_ph_d  = flush_ph_q;
        fir_d       = fir_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    flush_ph_d = 1'b0;
                    if (frame_len != '0) begin
                        len_d   = frame_len;
                        state_d = FEED;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FEED: begin
                if (s_valid) begin
                    fir_d    = s_data;
                    in_cnt_d = in_cnt_q + IN_ONE;
                    hold_d   = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    m_data_d  = fir_out;
                    m_valid_d = 1'b1;
                    state_d   = EMIT;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    out_cnt_d = out_cnt_q + OUT_ONE;
                    if (!flush_ph_q) begin
                        if (in_cnt_q != len_q) begin
                            state_d = FEED;
                        end else begin
                            fir_d       = '0;
                            flush_cnt_d = '0;
                            flush_ph_d  = 1'b1;
                            state_d     = FLUSH;
                        end
                    end else if (flush_cnt_q < FLUSH_LAST) begin
                        flush_cnt_d = flush_cnt_q + FLUSH_ONE;
                        hold_d      = '0;
                        state_d     = HOLD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FLUSH: begin
                // Zero sample is already on fir_data_in; start its hold.
                hold_d  = '0;
                state_d = HOLD;
            end
            DONE: begin
                fir_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_ready     = (state_q == FEED);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign fir_data_in = fir_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign in_count    = in_cnt_q;
    assign out_count   = out_cnt_q;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb_fir_stream_sequencer: randomized self-checking bench for fir_stream_sequencer.
// fir_out is random every cycle; expected captures come from the value seen at the edge.
module tb_fir_stream_sequencer;

    localparam int DATA_W = 16;
    localparam int TAPS   = 17;
    localparam int HOLD   = 2;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [DATA_W-1:0] fir_data_in;
    logic [DATA_W-1:0] fir_out;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  in_count;
    logic [LEN_W:0]    out_count;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] fir_prev;
    logic [DATA_W-1:0] samp_q[$];

    fir_stream_sequencer #(
        .DATA_W(DATA_W), .TAPS(TAPS), .HOLD_CYCLES(HOLD), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fir_data_in(fir_data_in), .fir_out(fir_out),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .done(done), .in_count(in_count), .out_count(out_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; fir_prev is the fir_out value present at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        fir_prev = fir_out;
        fir_out  = DATA_W'($urandom);
    endtask

    // Let the frame run to IDLE with the sink always ready, counting beats.
    task automatic drain(output int beats, output bit ok);
        beats = 0;
        ok    = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            m_ready = 1'b1;
            s_valid = 1'b0;
            if (m_valid) beats++;
            tick();
        end
    endtask

    // Run one full frame from samp_q, checking each capture against the model.
    task automatic run_frame(input string nm, input int len, input bit rnd);
        int si, beats, dones, rises, exp_beats;
        bit fin;
        logic mv_prev;
        logic [DATA_W-1:0] exp_in;
        si = 0; beats = 0; dones = 0; rises = 0; mv_prev = 1'b0; fin = 1'b0;
        exp_beats = (len == 0) ? 0 : len + TAPS - 1;
        start = 1'b1; frame_len = LEN_W'(len); s_valid = 1'b0; m_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done) dones++;
            if (m_valid && !mv_prev) begin
                exp_in = (rises < len) ? samp_q[rises] : '0;
                tests++;
                if (m_data !== fir_prev) begin
                    fails++;
                    $display("FAIL %s m_data beat %0d: got %h want %h",
                             nm, rises, m_data, fir_prev);
                end
                tests++;
                if (fir_data_in !== exp_in) begin
                    fails++;
                    $display("FAIL %s fir_data_in beat %0d: got %h want %h",
                             nm, rises, fir_data_in, exp_in);
                end
                rises++;
            end
            mv_prev = m_valid;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = (si < len) ? samp_q[si] : DATA_W'($urandom);
            start   = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
            frame_len = LEN_W'($urandom_range(0, 9));
            if (s_valid && s_ready) si++;
            if (m_valid && m_ready) beats++;
            tick();
        end
        start = 1'b0;
        tests++;
        if (!fin || beats != exp_beats || dones != 1) begin
            fails++;
            $display("FAIL %s frame: fin=%0d beats=%0d dones=%0d want beats=%0d dones=1",
                     nm, fin, beats, dones, exp_beats);
        end
        tests++;
        if (out_count !== (LEN_W + 1)'(exp_beats) || in_count !== LEN_W'(len)) begin
            fails++;
            $display("FAIL %s counts: got in=%0d out=%0d want in=%0d out=%0d",
                     nm, in_count, out_count, len, exp_beats);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; frame_len = '0; s_valid = 1'b0;
        s_data = '0; m_ready = 1'b0; fir_out = '0;
        tick();
        tick();
        tests++;
        if ({s_ready, busy, done, m_valid, fir_data_in, m_data, in_count, out_count} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b m_valid=%b fir=%h out=%0d want all 0",
                     busy, m_valid, fir_data_in, out_count);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b s_ready=%b want 0 0", busy, s_ready);
        end
    endtask

    task automatic test_spec_frame();
        samp_q = '{16'h0100, 16'h0200, 16'hFF00, 16'h0001};
        run_frame("spec_frame", 4, 1'b0);
    endtask

    task automatic test_timing();
        int beats;
        bit ok;
        samp_q = '{16'h1234};
        start = 1'b1; frame_len = 16'd1; m_ready = 1'b0; s_valid = 1'b0;
        tick();
        start = 1'b0;
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL timing_s_ready: got %b want 1", s_ready);
        end
        s_valid = 1'b1; s_data = 16'h1234;
        tick();
        s_valid = 1'b0;
        for (int c = 1; c <= HOLD; c++) begin
            tests++;
            if (fir_data_in !== 16'h1234 || m_valid !== 1'b0) begin
                fails++;
                $display("FAIL timing_hold t+%0d: got fir=%h m_valid=%b want 1234 0",
                         c, fir_data_in, m_valid);
            end
            tick();
        end
        tests++;
        if (m_valid !== 1'b1 || m_data !== fir_prev) begin
            fails++;
            $display("FAIL timing_emit: got m_valid=%b m_data=%h want 1 %h",
                     m_valid, m_data, fir_prev);
        end
        drain(beats, ok);
        tests++;
        if (!ok || beats != TAPS || out_count !== (LEN_W + 1)'(TAPS)) begin
            fails++;
            $display("FAIL timing_frame: ok=%0d beats=%0d out=%0d want %0d",
                     ok, beats, out_count, TAPS);
        end
    endtask

    task automatic test_stall();
        int beats;
        bit ok, seen;
        logic [DATA_W-1:0] md, fd;
        start = 1'b1; frame_len = 16'd1; m_ready = 1'b0;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 16'hBEEF;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        md = m_data;
        fd = fir_data_in;
        tests++;
        if (!seen || fd !== 16'hBEEF || md !== fir_prev) begin
            fails++;
            $display("FAIL stall_first: seen=%0d fir=%h m_data=%h want BEEF %h",
                     seen, fd, md, fir_prev);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (m_valid !== 1'b1 || m_data !== md || fir_data_in !== fd || s_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold %0d: got mv=%b md=%h fir=%h sr=%b want 1 %h %h 0",
                         k, m_valid, m_data, fir_data_in, s_ready, md, fd);
            end
        end
        drain(beats, ok);
        tests++;
        if (!ok || beats != TAPS || out_count !== (LEN_W + 1)'(TAPS)) begin
            fails++;
            $display("FAIL stall_frame: ok=%0d beats=%0d out=%0d want %0d",
                     ok, beats, out_count, TAPS);
        end
    endtask

    task automatic test_zero_len();
        int dones, mv;
        dones = 0; mv = 0;
        start = 1'b1; frame_len = '0; m_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k < 2 && done) dones++;
            if (m_valid) mv++;
            tick();
        end
        tests++;
        if (dones != 1 || mv != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_len: dones=%0d beats=%0d busy=%b want 1 0 0", dones, mv, busy);
        end
        tests++;
        if (out_count !== '0 || in_count !== '0) begin
            fails++;
            $display("FAIL zero_len_counts: got in=%0d out=%0d want 0 0", in_count, out_count);
        end
    endtask

    task automatic test_reset_mid();
        int rises, dones;
        logic mv_prev;
        rises = 0; dones = 0; mv_prev = 1'b0;
        start = 1'b1; frame_len = 16'd1; m_ready = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 16'h5A5A;
        for (int k = 0; k < 300; k++) begin
            if (m_valid && !mv_prev) rises++;
            mv_prev = m_valid;
            if (rises == 4) break;
            tick();
        end
        tests++;
        if (rises != 4) begin
            fails++;
            $display("FAIL reset_mid_reach: got %0d beats want 4", rises);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({s_ready, busy, done, m_valid, fir_data_in, m_data, in_count, out_count} !== '0) begin
            fails++;
            $display("FAIL reset_mid_async: got busy=%b mv=%b out=%0d want all 0",
                     busy, m_valid, out_count);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) dones++;
        end
        reset = 1'b0;
        tick();
        if (done) dones++;
        tests++;
        if (dones != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_nodone: dones=%0d busy=%b want 0 0", dones, busy);
        end
        samp_q = '{16'h7FFF};
        run_frame("post_reset", 1, 1'b0);
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 6);
            samp_q = {};
            for (int i = 0; i < len; i++) samp_q.push_back(DATA_W'($urandom));
            run_frame($sformatf("random%0d", r), len, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        samp_q = {16'h8000, 16'h0001};
        run_frame("b2b_a", 2, 1'b0);
        samp_q = {16'hAAAA, 16'h5555, 16'h0F0F};
        run_frame("b2b_b", 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_timing();
        test_stall();
        test_zero_len();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
